net_to_tran: RTL and testbench
==============================

Name: net_to_tran

Overview:
- Receive-side counterpart of the transport-to-network packetiser. Accepts byte-serial packets from the network layer, strips the leading phone-number byte and buffers exactly packetSize payload bytes in an internal FIFO. Presents the complete packet to the transport layer, which pulls it out byte by byte.
- Incomplete packets are discarded and counted.

Parameters:
- packetSize, 16, payload bytes per packet, excluding the phone byte; range 1..255.
- countWidth, 5, width of bufferCount; must satisfy 2^countWidth > packetSize.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- data  input  8  byte from network layer.
- receiving  input  1  data is valid this cycle; must stay high for a packet's full duration.
- tranRd  input  1  transport-layer read strobe; pops one byte.
- recvReady  output  1  block accepts a new packet (state IDLE or PAYLOAD).
- phoneNum  output  8  caller phone byte of the last accepted packet.
- packetReady  output  1  complete packet buffered and available.
- dataOut  output  8  popped payload byte.
- dataOutValid  output  1  dataOut valid; one-cycle pulse per pop.
- bufferCount  output  countWidth  bytes currently in FIFO.
- abortCount  output  8  aborted packets; saturates at 255.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, recvReady=1, phoneNum=0, packetReady=0, dataOut=0, dataOutValid=0, bufferCount=0, abortCount=0, FIFO pointers=0. Reset mid-packet discards the packet silently; abortCount is cleared, not incremented.
- FIFO: register array, depth packetSize; write and read pointers wrap modulo packetSize. No vendor core.
- State IDLE:
  - recvReady=1, packetReady=0.
  - On receiving=1: phoneNum<=data; go to PAYLOAD. This first byte is never written to the FIFO.
- State PAYLOAD:
  - recvReady=1.
  - On receiving=1: write data at wrPtr; bufferCount+1.
  - On the edge writing byte number packetSize: go to DELIVER; recvReady=0 from the next cycle.
  - On receiving=0 before the last byte (abort): flush FIFO (pointers=0, bufferCount=0); abortCount+1, saturating at 255; go to IDLE. phoneNum keeps the aborted packet's value.
- State DELIVER:
  - recvReady=0, packetReady=1.
  - receiving and data are ignored; the network must honour recvReady, and extra bytes are dropped with no error.
  - On tranRd=1 with bufferCount>0: dataOut<=mem[rdPtr]; dataOutValid=1 in the following cycle only; bufferCount-1. Read latency is 1 cycle.
  - tranRd held high continuously pops one byte per cycle.
  - On the edge popping the last byte (bufferCount 1→0): go to IDLE; packetReady=0 and recvReady=1 from the next cycle.
  - tranRd with bufferCount=0, or in IDLE/PAYLOAD: ignored; dataOutValid stays 0 and dataOut holds its value.
- Back-to-back packets:
  - receiving may rise in the first IDLE cycle after DELIVER ends.
  - The minimum gap between packets is the DELIVER drain time.
  - receiving held high from DELIVER into IDLE: the first IDLE-cycle byte is taken as the phone byte.
- Simultaneous receiving and tranRd: impossible by construction, because writes occur only in PAYLOAD and reads only in DELIVER.
- Widths: bufferCount never exceeds packetSize. The abortCount increment is saturating.

Test Plan:
- Reset then idle: hold reset=0 three cycles, release → recvReady=1, packetReady=0, bufferCount=0, abortCount=0, phoneNum=0.
- Single packet: receiving=1 for 17 cycles, data=0x42 then 0x00..0x0F → phoneNum=0x42, bufferCount=16, packetReady=1, recvReady=0. Then tranRd=1 for 16 cycles → dataOutValid pulses 16 times, one cycle after each read, with dataOut=0x00..0x0F in order; packetReady=0 and recvReady=1 after the last pop.
- Abort: phone byte 0x07 plus 5 payload bytes, then receiving=0 → bufferCount=0, abortCount=1, state IDLE. A following full packet is delivered correctly, proving the pointers restart at 0.
- Overrun/underrun: with a packet pending, drive receiving=1 with data=0xFF → buffer contents unchanged. tranRd=1 with an empty buffer → no dataOutValid, dataOut unchanged.
- Abort saturation: 260 aborted packets → abortCount=255.
- Async reset mid-delivery: after 8 of 16 pops, assert reset=0 between clock edges → all outputs at reset values before the next edge; next packet delivered intact.

Source files
------------

// File: rtl/net_to_tran.sv
// net_to_tran -- receive side of the network-to-transport path.
//
// Takes byte-serial packets from the network layer. The first byte of each
// packet is the caller phone number and is latched into phoneNum; the next
// packetSize bytes are buffered in a small register FIFO. The complete packet
// is then offered to the transport layer, which pops it one byte per tranRd.
// A packet whose receiving strobe drops early is discarded and counted.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   data         in   [7:0] byte from network layer
//   receiving    in   data valid; held high for a packet's full duration
//   tranRd       in   transport read strobe, pops one byte
//   recvReady    out  block accepts a new packet (IDLE or PAYLOAD)
//   phoneNum     out  [7:0] phone byte of the last accepted packet
//   packetReady  out  complete packet buffered and available
//   dataOut      out  [7:0] popped payload byte
//   dataOutValid out  one-cycle pulse per pop, one cycle after tranRd
//   bufferCount  out  [countWidth-1:0] bytes currently in FIFO
//   abortCount   out  [7:0] aborted packets, saturating at 255
module net_to_tran #(
  parameter int unsigned packetSize = 16,
  parameter int unsigned countWidth = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data,
  input  logic                  receiving,
  input  logic                  tranRd,
  output logic                  recvReady,
  output logic [7:0]            phoneNum,
  output logic                  packetReady,
  output logic [7:0]            dataOut,
  output logic                  dataOutValid,
  output logic [countWidth-1:0] bufferCount,
  output logic [7:0]            abortCount
);

  localparam int unsigned PTR_W = (packetSize > 1) ? $clog2(packetSize) : 1;
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(packetSize - 1);
  localparam logic [countWidth-1:0] LAST_CNT = countWidth'(packetSize - 1);
  localparam logic [countWidth-1:0] ONE_CNT  = countWidth'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [packetSize];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [countWidth-1:0] r_count;
  logic [7:0]            r_phoneNum;
  logic [7:0]            r_dataOut;
  logic                  r_dataOutValid;
  logic [7:0]            r_abortCount;

  logic                  w_wr;
  logic                  w_rd;
  logic [PTR_W-1:0]      w_wrPtrNext;
  logic [PTR_W-1:0]      w_rdPtrNext;

  // Writes only happen in PAYLOAD and reads only in DELIVER, so the FIFO
  // never sees a simultaneous push and pop.
  assign w_wr = (r_state == S_PAYLOAD) && receiving;
  assign w_rd = (r_state == S_DELIVER) && tranRd && (r_count != '0);

  assign w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
  assign w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);

  assign recvReady    = (r_state != S_DELIVER);
  assign packetReady  = (r_state == S_DELIVER);
  assign phoneNum     = r_phoneNum;
  assign dataOut      = r_dataOut;
  assign dataOutValid = r_dataOutValid;
  assign bufferCount  = r_count;
  assign abortCount   = r_abortCount;

  // Payload storage carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wrPtr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wrPtr        <= '0;
      r_rdPtr        <= '0;
      r_count        <= '0;
      r_phoneNum     <= '0;
      r_dataOut      <= '0;
      r_dataOutValid <= 1'b0;
      r_abortCount   <= '0;
    end else begin
      r_dataOutValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (receiving) begin
            r_phoneNum <= data;
            r_state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (receiving) begin
            r_wrPtr <= w_wrPtrNext;
            r_count <= r_count + ONE_CNT;
            if (r_count == LAST_CNT) begin
              r_state <= S_DELIVER;
            end
          end else begin
            // Early drop of receiving: discard the partial packet.
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            if (r_abortCount != 8'hFF) begin
              r_abortCount <= r_abortCount + 8'd1;
            end
            r_state <= S_IDLE;
          end
        end
        S_DELIVER: begin
          if (w_rd) begin
            r_dataOut      <= r_mem[r_rdPtr];
            r_dataOutValid <= 1'b1;
            r_rdPtr        <= w_rdPtrNext;
            r_count        <= r_count - ONE_CNT;
            if (r_count == ONE_CNT) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_net_to_tran.sv
module tb_net_to_tran;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       receiving;
  logic       tranRd;
  logic       recvReady;
  logic [7:0] phoneNum;
  logic       packetReady;
  logic [7:0] dataOut;
  logic       dataOutValid;
  logic [4:0] bufferCount;
  logic [7:0] abortCount;

  int unsigned n_pass;
  int unsigned n_total;

  net_to_tran #(
    .packetSize(16),
    .countWidth(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .receiving   (receiving),
    .tranRd      (tranRd),
    .recvReady   (recvReady),
    .phoneNum    (phoneNum),
    .packetReady (packetReady),
    .dataOut     (dataOut),
    .dataOutValid(dataOutValid),
    .bufferCount (bufferCount),
    .abortCount  (abortCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: phone byte then n payload bytes base, base+1, ...
  // Entered and left at a falling edge; receiving is low on return.
  task automatic send_bytes(input logic [7:0] phone, input logic [7:0] base,
                            input int unsigned n);
    receiving = 1'b1;
    data      = phone;
    @(negedge clk);
    for (int unsigned i = 0; i < n; i++) begin
      data = 8'(base + i);
      @(negedge clk);
    end
    receiving = 1'b0;
    data      = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b0; receiving = 1'b0; tranRd = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (recvReady !== 1'b1) $display("FAIL rst_recvReady got %0b exp 1", recvReady); else n_pass++;
    n_total++; if (packetReady !== 1'b0) $display("FAIL rst_packetReady got %0b exp 0", packetReady); else n_pass++;
    n_total++; if (bufferCount !== 5'd0) $display("FAIL rst_bufferCount got %0d exp 0", bufferCount); else n_pass++;
    n_total++; if (abortCount !== 8'd0) $display("FAIL rst_abortCount got %0d exp 0", abortCount); else n_pass++;
    n_total++; if (phoneNum !== 8'h00) $display("FAIL rst_phoneNum got %h exp 00", phoneNum); else n_pass++;
    n_total++; if (dataOutValid !== 1'b0) $display("FAIL rst_dataOutValid got %0b exp 0", dataOutValid); else n_pass++;
  endtask

  task automatic test_single_packet;
    send_bytes(8'h42, 8'h00, 16);
    n_total++; if (phoneNum !== 8'h42) $display("FAIL pkt_phoneNum got %h exp 42", phoneNum); else n_pass++;
    n_total++; if (bufferCount !== 5'd16) $display("FAIL pkt_full_count got %0d exp 16", bufferCount); else n_pass++;
    n_total++; if (packetReady !== 1'b1) $display("FAIL pkt_packetReady got %0b exp 1", packetReady); else n_pass++;
    n_total++; if (recvReady !== 1'b0) $display("FAIL pkt_recvReady got %0b exp 0", recvReady); else n_pass++;
    n_total++; if (dataOutValid !== 1'b0) $display("FAIL pkt_valid_before_read got %0b exp 0", dataOutValid); else n_pass++;
    for (int unsigned i = 0; i < 16; i++) begin
      tranRd = 1'b1;
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b1) $display("FAIL pkt_pop%0d_valid got %0b exp 1", i, dataOutValid); else n_pass++;
      n_total++; if (dataOut !== 8'(i)) $display("FAIL pkt_pop%0d_data got %h exp %h", i, dataOut, 8'(i)); else n_pass++;
      n_total++; if (bufferCount !== 5'(15 - i)) $display("FAIL pkt_pop%0d_count got %0d exp %0d", i, bufferCount, 15 - i); else n_pass++;
    end
    tranRd = 1'b0;
    n_total++; if (packetReady !== 1'b0) $display("FAIL pkt_drained_packetReady got %0b exp 0", packetReady); else n_pass++;
    n_total++; if (recvReady !== 1'b1) $display("FAIL pkt_drained_recvReady got %0b exp 1", recvReady); else n_pass++;
    @(negedge clk);
    n_total++; if (dataOutValid !== 1'b0) $display("FAIL pkt_valid_pulse_end got %0b exp 0", dataOutValid); else n_pass++;
  endtask

  task automatic test_abort;
    send_bytes(8'h07, 8'hA0, 5);
    @(negedge clk);
    n_total++; if (bufferCount !== 5'd0) $display("FAIL abort_count got %0d exp 0", bufferCount); else n_pass++;
    n_total++; if (abortCount !== 8'd1) $display("FAIL abort_abortCount got %0d exp 1", abortCount); else n_pass++;
    n_total++; if (recvReady !== 1'b1) $display("FAIL abort_recvReady got %0b exp 1", recvReady); else n_pass++;
    n_total++; if (packetReady !== 1'b0) $display("FAIL abort_packetReady got %0b exp 0", packetReady); else n_pass++;
    n_total++; if (phoneNum !== 8'h07) $display("FAIL abort_phoneNum got %h exp 07", phoneNum); else n_pass++;
    send_bytes(8'h55, 8'h10, 16);
    n_total++; if (phoneNum !== 8'h55) $display("FAIL abort_next_phoneNum got %h exp 55", phoneNum); else n_pass++;
    n_total++; if (bufferCount !== 5'd16) $display("FAIL abort_next_count got %0d exp 16", bufferCount); else n_pass++;
    for (int unsigned i = 0; i < 16; i++) begin
      tranRd = 1'b1;
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b1 || dataOut !== 8'(8'h10 + i))
        $display("FAIL abort_next_pop%0d got v=%0b d=%h exp v=1 d=%h", i, dataOutValid, dataOut, 8'(8'h10 + i)); else n_pass++;
    end
    tranRd = 1'b0;
    n_total++; if (abortCount !== 8'd1) $display("FAIL abort_count_kept got %0d exp 1", abortCount); else n_pass++;
  endtask

  task automatic test_overrun_underrun;
    send_bytes(8'h33, 8'h20, 16);
    receiving = 1'b1;
    data      = 8'hFF;
    repeat (3) @(negedge clk);
    receiving = 1'b0;
    data      = 8'h00;
    n_total++; if (bufferCount !== 5'd16) $display("FAIL over_count got %0d exp 16", bufferCount); else n_pass++;
    n_total++; if (phoneNum !== 8'h33) $display("FAIL over_phoneNum got %h exp 33", phoneNum); else n_pass++;
    n_total++; if (packetReady !== 1'b1) $display("FAIL over_packetReady got %0b exp 1", packetReady); else n_pass++;
    for (int unsigned i = 0; i < 16; i++) begin
      tranRd = 1'b1;
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b1 || dataOut !== 8'(8'h20 + i))
        $display("FAIL over_pop%0d got v=%0b d=%h exp v=1 d=%h", i, dataOutValid, dataOut, 8'(8'h20 + i)); else n_pass++;
    end
    // tranRd kept high into IDLE with the buffer empty
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b0) $display("FAIL under%0d_valid got %0b exp 0", i, dataOutValid); else n_pass++;
      n_total++; if (dataOut !== 8'h2F) $display("FAIL under%0d_data got %h exp 2f", i, dataOut); else n_pass++;
      n_total++; if (bufferCount !== 5'd0) $display("FAIL under%0d_count got %0d exp 0", i, bufferCount); else n_pass++;
    end
    tranRd = 1'b0;
  endtask

  task automatic test_abort_saturation;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int unsigned k = 1; k <= 260; k++) begin
      receiving = 1'b1;
      data      = 8'(k);
      @(negedge clk);
      data = 8'hEE;
      @(negedge clk);
      receiving = 1'b0;
      @(negedge clk);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 260) begin
        n_total++; if (abortCount !== 8'((k > 255) ? 255 : k))
          $display("FAIL sat_after_%0d got %0d exp %0d", k, abortCount, (k > 255) ? 255 : k); else n_pass++;
      end
    end
    n_total++; if (bufferCount !== 5'd0) $display("FAIL sat_count got %0d exp 0", bufferCount); else n_pass++;
  endtask

  task automatic test_async_reset;
    send_bytes(8'h61, 8'h30, 16);
    for (int unsigned i = 0; i < 8; i++) begin
      tranRd = 1'b1;
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b1 || dataOut !== 8'(8'h30 + i))
        $display("FAIL arst_pop%0d got v=%0b d=%h exp v=1 d=%h", i, dataOutValid, dataOut, 8'(8'h30 + i)); else n_pass++;
    end
    tranRd = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_total++; if (recvReady !== 1'b1) $display("FAIL arst_recvReady got %0b exp 1", recvReady); else n_pass++;
    n_total++; if (packetReady !== 1'b0) $display("FAIL arst_packetReady got %0b exp 0", packetReady); else n_pass++;
    n_total++; if (phoneNum !== 8'h00) $display("FAIL arst_phoneNum got %h exp 00", phoneNum); else n_pass++;
    n_total++; if (dataOut !== 8'h00) $display("FAIL arst_dataOut got %h exp 00", dataOut); else n_pass++;
    n_total++; if (dataOutValid !== 1'b0) $display("FAIL arst_dataOutValid got %0b exp 0", dataOutValid); else n_pass++;
    n_total++; if (bufferCount !== 5'd0) $display("FAIL arst_bufferCount got %0d exp 0", bufferCount); else n_pass++;
    n_total++; if (abortCount !== 8'd0) $display("FAIL arst_abortCount got %0d exp 0", abortCount); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_bytes(8'h62, 8'h40, 16);
    n_total++; if (phoneNum !== 8'h62) $display("FAIL arst_next_phoneNum got %h exp 62", phoneNum); else n_pass++;
    n_total++; if (bufferCount !== 5'd16) $display("FAIL arst_next_count got %0d exp 16", bufferCount); else n_pass++;
    for (int unsigned i = 0; i < 16; i++) begin
      tranRd = 1'b1;
      @(negedge clk);
      n_total++; if (dataOutValid !== 1'b1 || dataOut !== 8'(8'h40 + i))
        $display("FAIL arst_next_pop%0d got v=%0b d=%h exp v=1 d=%h", i, dataOutValid, dataOut, 8'(8'h40 + i)); else n_pass++;
    end
    tranRd = 1'b0;
    n_total++; if (recvReady !== 1'b1 || packetReady !== 1'b0)
      $display("FAIL arst_next_drained got rr=%0b pr=%0b exp rr=1 pr=0", recvReady, packetReady); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset = 1'b0; receiving = 1'b0; tranRd = 1'b0; data = 8'h00;
    @(negedge clk);
    test_reset;
    test_single_packet;
    test_abort;
    test_overrun_underrun;
    test_abort_saturation;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
